// File: rtl/delta_event_fifo.sv
// delta_event_fifo: timestamps comparator spike events and buffers them in a first-word-fall-through FIFO.
// Optional wrap marker entries are enabled with `define DELTA_EVT_WRAP_MARKER_EN.
module delta_event_fifo #(
  parameter int TS_W  = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_valid,
  input  logic [1:0]               spike,
  input  logic                     clear_ovf,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [TS_W+1:0]          out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [TS_W+1:0] mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic            ovf_q, ovf_d;
  logic            evt_req, pop, room, evt_push, drop, mk_push, push;
  logic [TS_W+1:0] wdata;
`ifdef DELTA_EVT_WRAP_MARKER_EN
  logic            mk_pend_q, mk_pend_d;
`endif
  assign out_valid = level_q != '0;
  assign out_data  = out_valid ? mem_q[rptr_q] : '0;
  assign level     = level_q;
  assign overflow  = ovf_q;
  always_comb begin
    evt_req  = sample_valid & spike[0];
    pop      = out_valid & out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    room     = (level_q != LW'(DEPTH)) | pop;
    evt_push = evt_req & room;
    drop     = evt_req & !room;
`ifdef DELTA_EVT_WRAP_MARKER_EN
    mk_push   = mk_pend_q & !evt_req & room;
    mk_pend_d = (sample_valid & (ts_q == '1)) | (mk_pend_q & !mk_push);
`else
    mk_push   = 1'b0;
`endif
    push     = evt_push | mk_push;
    wdata    = evt_push ? {spike[1], 1'b1, ts_q} : {2'b10, {TS_W{1'b0}}};
    ts_d     = sample_valid ? ts_q + 1'b1 : ts_q;
    wptr_d   = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d   = pop ? rptr_q + 1'b1 : rptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
    ovf_d    = drop | (ovf_q & !clear_ovf);
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wdata;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ts_q    <= '0;
      ovf_q   <= 1'b0;
`ifdef DELTA_EVT_WRAP_MARKER_EN
      mk_pend_q <= 1'b0;
`endif
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ts_q    <= ts_d;
      ovf_q   <= ovf_d;
`ifdef DELTA_EVT_WRAP_MARKER_EN
      mk_pend_q <= mk_pend_d;
`endif
    end
  end
endmodule

// File: tb/tb_delta_event_fifo.sv
// tb_delta_event_fifo: directed self-checking bench for delta_event_fifo.
module tb_delta_event_fifo;
`ifdef DELTA_EVT_WRAP_MARKER_EN
  localparam int TS_W = 4;
`else
  localparam int TS_W = 8;
`endif
  localparam int DEPTH = 8;
  localparam int W = TS_W + 2;
  logic clk = 1'b0, reset = 1'b0, sample_valid = 1'b0, clear_ovf = 1'b0, out_ready = 1'b0;
  logic [1:0] spike = 2'b00;
  logic out_valid, overflow;
  logic [W-1:0] out_data;
  logic [$clog2(DEPTH):0] level;
  int checks = 0, failures = 0;
  delta_event_fifo #(.TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .spike(spike),
    .clear_ovf(clear_ovf), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .level(level), .overflow(overflow)
  );
  always #5 clk = ~clk;
  function automatic logic [W-1:0] ev(input logic [1:0] t, input int ts);
    logic [TS_W-1:0] tsv;
    tsv = TS_W'(ts);
    return {t, tsv};
  endfunction
  task automatic cyc(input logic sv, input logic [1:0] sp);
    sample_valid = sv;
    spike = sp;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    spike = 2'b00;
  endtask
  task automatic do_reset();
    sample_valid = 1'b0; spike = 2'b00; clear_ovf = 1'b0; out_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_data got %h exp 0", out_data); end
    checks++; if (level !== '0) begin failures++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got %b exp 0", overflow); end
  endtask
  task automatic test_basic();
    do_reset();
    out_ready = 1'b1;
    cyc(1'b1, 2'b01);
    checks++; if (out_valid !== 1'b1 || out_data !== ev(2'b01, 0)) begin failures++; $display("FAIL basic_on got %b/%h exp 1/%h", out_valid, out_data, ev(2'b01, 0)); end
    cyc(1'b1, 2'b00);
    checks++; if (level !== '0 || out_data !== '0) begin failures++; $display("FAIL basic_pop got %0d/%h exp 0/0", level, out_data); end
    cyc(1'b1, 2'b11);
    checks++; if (out_valid !== 1'b1 || out_data !== ev(2'b11, 2)) begin failures++; $display("FAIL basic_off got %b/%h exp 1/%h", out_valid, out_data, ev(2'b11, 2)); end
    cyc(1'b0, 2'b00);
    checks++; if (level !== '0 || out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got %0d/%b exp 0/0", level, out_valid); end
  endtask
  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b1, 2'b01);
    checks++; if (level !== 4'd8) begin failures++; $display("FAIL ovf_level got %0d exp 8", level); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (out_data !== ev(2'b01, i)) begin failures++; $display("FAIL ovf_drain%0d got %h exp %h", i, out_data, ev(2'b01, i)); end
      cyc(1'b0, 2'b00);
    end
    checks++; if (level !== '0) begin failures++; $display("FAIL ovf_empty got %0d exp 0", level); end
  endtask
  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 2'b01);
    checks++; if (level !== 4'd8 || overflow !== 1'b0) begin failures++; $display("FAIL full_fill got %0d/%b exp 8/0", level, overflow); end
    cyc(1'b1, 2'b01);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL full_drop got %b exp 1", overflow); end
    out_ready = 1'b1;
    cyc(1'b1, 2'b01);
    out_ready = 1'b0;
    checks++; if (level !== 4'd8 || overflow !== 1'b1) begin failures++; $display("FAIL full_pushpop got %0d/%b exp 8/1", level, overflow); end
    checks++; if (out_data !== ev(2'b01, 1)) begin failures++; $display("FAIL full_head got %h exp %h", out_data, ev(2'b01, 1)); end
    clear_ovf = 1'b1;
    cyc(1'b1, 2'b01);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL clear_vs_drop got %b exp 1", overflow); end
    cyc(1'b0, 2'b00);
    clear_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL clear_ovf got %b exp 0", overflow); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (out_data !== ev(2'b01, i < 7 ? i + 1 : 9)) begin failures++; $display("FAIL full_drain%0d got %h exp %h", i, out_data, ev(2'b01, i < 7 ? i + 1 : 9)); end
      cyc(1'b0, 2'b00);
    end
    checks++; if (level !== '0) begin failures++; $display("FAIL full_empty got %0d exp 0", level); end
  endtask
  task automatic test_hold();
    do_reset();
    cyc(1'b1, 2'b01);
    cyc(1'b1, 2'b10);
    checks++; if (level !== 4'd1 || out_data !== ev(2'b01, 0)) begin failures++; $display("FAIL hold_10 got %0d/%h exp 1/%h", level, out_data, ev(2'b01, 0)); end
    cyc(1'b0, 2'b00);
    checks++; if (out_data !== ev(2'b01, 0)) begin failures++; $display("FAIL hold_stable got %h exp %h", out_data, ev(2'b01, 0)); end
    cyc(1'b1, 2'b01);
    checks++; if (level !== 4'd2 || out_data !== ev(2'b01, 0)) begin failures++; $display("FAIL hold_push got %0d/%h exp 2/%h", level, out_data, ev(2'b01, 0)); end
    out_ready = 1'b1;
    cyc(1'b0, 2'b00);
    checks++; if (out_data !== ev(2'b01, 2)) begin failures++; $display("FAIL hold_ts got %h exp %h", out_data, ev(2'b01, 2)); end
  endtask
  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 9; i++) cyc(1'b1, 2'b01);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'b00);
    out_ready = 1'b0;
    checks++; if (level !== 4'd5 || overflow !== 1'b1) begin failures++; $display("FAIL ares_pre got %0d/%b exp 5/1", level, overflow); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || level !== '0 || overflow !== 1'b0) begin failures++; $display("FAIL ares_async got %b/%0d/%b exp 0/0/0", out_valid, level, overflow); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1'b1, 2'b01);
    checks++; if (out_data !== ev(2'b01, 0) || level !== 4'd1) begin failures++; $display("FAIL ares_ts got %h/%0d exp %h/1", out_data, level, ev(2'b01, 0)); end
  endtask
  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < (1 << TS_W) - 1; i++) cyc(1'b1, 2'b00);
    cyc(1'b1, 2'b01);
    cyc(1'b1, 2'b01);
    cyc(1'b0, 2'b00);
    cyc(1'b0, 2'b00);
`ifdef DELTA_EVT_WRAP_MARKER_EN
    checks++; if (level !== 4'd3) begin failures++; $display("FAIL wrap_level got %0d exp 3", level); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL wrap_ovf got %b exp 0", overflow); end
    out_ready = 1'b1;
    checks++; if (out_data !== ev(2'b01, (1 << TS_W) - 1)) begin failures++; $display("FAIL wrap_e0 got %h exp %h", out_data, ev(2'b01, (1 << TS_W) - 1)); end
    cyc(1'b0, 2'b00);
    checks++; if (out_data !== ev(2'b01, 0)) begin failures++; $display("FAIL wrap_e1 got %h exp %h", out_data, ev(2'b01, 0)); end
    cyc(1'b0, 2'b00);
    checks++; if (out_data !== ev(2'b10, 0)) begin failures++; $display("FAIL wrap_marker got %h exp %h", out_data, ev(2'b10, 0)); end
    cyc(1'b0, 2'b00);
    checks++; if (level !== '0) begin failures++; $display("FAIL wrap_empty got %0d exp 0", level); end
`else
    checks++; if (level !== 4'd2) begin failures++; $display("FAIL wrap_level got %0d exp 2", level); end
    out_ready = 1'b1;
    checks++; if (out_data !== ev(2'b01, (1 << TS_W) - 1)) begin failures++; $display("FAIL wrap_e0 got %h exp %h", out_data, ev(2'b01, (1 << TS_W) - 1)); end
    cyc(1'b0, 2'b00);
    checks++; if (out_data !== ev(2'b01, 0)) begin failures++; $display("FAIL wrap_e1 got %h exp %h", out_data, ev(2'b01, 0)); end
    cyc(1'b0, 2'b00);
    checks++; if (level !== '0 || out_data !== '0) begin failures++; $display("FAIL wrap_nomarker got %0d/%h exp 0/0", level, out_data); end
`endif
  endtask
  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_hold();
    test_async_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/delta_event_fifo.md
Name: delta_event_fifo

Overview:
- Downstream stage of the delta comparator: consumes its per-sample spike[1:0] code, tags each event with a sample timestamp, and buffers it.
- Presents events to the output/serial interface through a valid/ready handshake.
- Decouples the bursty spike stream from a slower consumer and flags lost events.

Parameters:
- TS_W, 8, timestamp (sample counter) width in bits.
- DEPTH, 8, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- sample_valid  input  1  one-cycle strobe: spike is valid for one sample this cycle.
- spike  input  2  comparator code: 00 none, 01 on-event, 11 off-event, 10 treated as none.
- clear_ovf  input  1  clears the sticky overflow flag.
- out_ready  input  1  consumer accepts the head entry this cycle.
- out_valid  output  1  head entry available.
- out_data  output  TS_W+2  {type[1:0], timestamp[TS_W-1:0]}; type 01 on, 11 off, 10 wrap marker.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky: an event was dropped.

Behaviour:
- Reset (async assert, sync release): FIFO empty, out_valid=0, out_data=0, level=0, overflow=0, ts counter=0, marker pending=0.
- Timestamp counter ts:
  - On each sample_valid: the current ts is the sample's timestamp, then ts <= ts+1, wrapping modulo 2^TS_W.
  - No change without sample_valid. The first sample after reset has timestamp 0.
- Push request: sample_valid && spike[0]. Written word = {spike[1],1'b1, ts}.
- Pop: out_valid && out_ready.
- FIFO is first-word-fall-through:
  - out_valid = (level != 0); out_data = head entry, held stable while out_valid && !out_ready.
  - out_data is 0 when empty.
- Latency: an event pushed at edge N gives out_valid=1 in the cycle after edge N, with no extra bubble.
- Simultaneous push and pop:
  - When not full: both occur and level is unchanged.
  - When full: pop frees a slot and the push is accepted (no drop), so level stays at DEPTH.
- Push while full with no pop: event dropped, FIFO unchanged, overflow <= 1.
- overflow stays 1 until clear_ovf.
  - If clear_ovf and a new drop occur in the same cycle, overflow = 1 (set wins).
- Push/pop on empty: a pop is impossible (out_valid=0); out_ready is ignored.
- Pointers are $clog2(DEPTH) bits and wrap naturally; level is kept as a separate counter of width $clog2(DEPTH)+1.
- Reset mid-operation discards all entries immediately, including any pending marker.

Optional Feature:
- Macro: DELTA_EVT_WRAP_MARKER_EN.
- Defined:
  - When ts wraps from 2^TS_W-1 to 0 on a sample, a marker-pending flag is set.
  - The marker {2'b10, TS_W'(0)} is pushed on the first subsequent cycle with no event push and level < DEPTH (or level == DEPTH with a pop that cycle).
  - Events always take priority over the marker.
  - A pending marker is never dropped and never sets overflow.
  - A second wrap while a marker is still pending does not queue a second marker.
- Not defined: no marker logic and no pending flag; type 10 is never produced.

Test Plan:
1. After reset, out_ready=1, sample_valid on 3 consecutive cycles with spike 01,00,11 → out_valid pulses carry {01,ts=0} then {11,ts=2}; level returns to 0.
2. DEPTH=8, out_ready=0, 10 on-events at ts 0..9 → level=8, overflow=1, and the entries drained afterwards have ts 0..7 in order.
3. With the FIFO full, out_ready=1 and an event pushed in the same cycle → the event is accepted, level stays 8, overflow unchanged; clear_ovf pulse → overflow=0.
4. Hold out_ready=0 with one entry, then apply spike=10 with sample_valid → no push, ts increments, and out_data stays stable across cycles.
5. Assert reset mid-burst with level=5 → out_valid=0, level=0, overflow=0 asynchronously; the next event gets ts=0.
6. DELTA_EVT_WRAP_MARKER_EN, TS_W=4: 17 samples, an on-event at sample 15 and sample 16, idle after → out sequence {01,15}, {01,0}, then {10,0}.
